seq_verdict_monitor: RTL
========================

// Module: seq_verdict_monitor
// PURPOSE
//  Downstream consumer of a sequence-operation checker (AND/OR/intersect style).
//  Tracks each attempt start (checker en) in order and pairs it with the next match/fail verdict.
//  Detects attempts that never get a verdict (timeout) and verdicts with no attempt (spurious).
//  Emits one result record per attempt on a valid/ready stream and keeps saturating pass/fail/timeout counters.
// PARAMETERS
//  DEPTH    8   max outstanding attempts (power of 2, >=2)
//  TIMEOUT  8   cycles from attempt to forced timeout verdict (checker window + pipeline slack)
//  RDEPTH   4   result FIFO depth (power of 2, >=2)
//  TS_W     16  free-running cycle counter / timestamp width
//  CNT_W    16  statistics counter width
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      synchronous active-low reset
//  clr          in   1      sync clear of counters and sticky flags (FIFOs untouched)
//  attempt      in   1      attempt-start pulse (driven by the checker's en)
//  match        in   1      checker match pulse
//  fail         in   1      checker fail pulse
//  res_valid    out  1      result record available
//  res_ready    in   1      consumer accepts record
//  res_code     out  2      01 pass, 10 fail, 11 timeout
//  res_lat      out  TS_W   cycles from attempt to verdict
//  pass_cnt     out  CNT_W  saturating pass count
//  fail_cnt     out  CNT_W  saturating fail count
//  tmo_cnt      out  CNT_W  saturating timeout count
//  err_spurious out  1      sticky: verdict with no outstanding attempt, or match&fail together
//  err_ovf      out  1      sticky: attempt or result dropped (FIFO full)
//  busy         out  1      >=1 attempt outstanding
// BEHAVIOUR
//  - Reset: all outputs 0; attempt FIFO, result FIFO and cycle counter empty/0. Reset mid-operation discards everything.
//  - Cycle counter: now increments every cycle and wraps. Latency = now - start_ts, computed mod 2^TS_W.
//  - Attempt FIFO: in order. attempt=1 pushes now. If the FIFO is full, the attempt is dropped and err_ovf is set.
//  - Verdict sources, evaluated per cycle against the head entry (oldest outstanding attempt):
//    - match=1 and fail=0: pop the head. Result is pass.
//    - fail=1: pop the head. Result is fail. If match=1 in the same cycle, err_spurious is also set.
//    - No verdict and head age == TIMEOUT: pop the head. Result is timeout (res_lat = TIMEOUT).
//    - A verdict in the same cycle that the head reaches TIMEOUT wins; it is not a timeout.
//    - A verdict while the FIFO is empty (before this cycle's push): err_spurious is set. Nothing is popped or counted.
//  - Same-cycle push and pop is legal, including when the FIFO is full (the pop frees the slot).
//  - At most one pop per cycle.
//  - Result FIFO: a pop writes a record next cycle (latency 1 from verdict to res_valid when the FIFO is empty).
//    - If the result FIFO is full, the record is dropped and err_ovf is set. Counters still update.
//    - Transfer occurs when res_valid && res_ready. The res_* fields are held stable while res_valid && !res_ready.
//  - Counters update in the verdict cycle and stick at 2^CNT_W-1.
//  - clr zeroes counters and sticky flags.
//    - An event in the same cycle as clr: clr wins and the event is not counted.
//  - busy = attempt FIFO non-empty (registered).
// CONFIGURATION
//  SEQ_MON_TIMESTAMP_EN defined:
//    - Adds output res_ts [TS_W] = now at the verdict cycle, stored in the result record.
//  SEQ_MON_TIMESTAMP_EN undefined:
//    - No res_ts port and no result-FIFO storage for it.
//    - All other behaviour is identical.
// TESTING
//  1. attempt@t0, match@t3, res_ready=1 -> res_valid@t4, code=01, lat=3; pass_cnt=1, busy=0 @t4.
//  2. attempt@t0, no verdict -> timeout pop @t8, res_valid@t9, code=11, lat=8; tmo_cnt=1.
//  3. attempts@t0,t1, fail@t4, match@t5 -> records (10, lat 4) then (01, lat 4) in order.
//  4. match with idle monitor; then match&fail with 1 outstanding -> err_spurious=1 both times; second gives code=10.
//  5. 9 back-to-back attempts (DEPTH=8), res_ready=0 with 5 verdicts -> err_ovf=1; 4 records retained; counters=5.
//  6. Assert rst_n=0 with 3 outstanding -> next cycle busy=0, res_valid=0, counters and flags 0; later match -> err_spurious.

Source files
------------

// File: rtl/seq_verdict_monitor.sv
// Pairs checker attempts with their match/fail verdicts, forces timeouts, streams result records
// and keeps saturating statistics. Define SEQ_MON_TIMESTAMP_EN to add the res_ts record field.
module seq_verdict_monitor #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 8,
   parameter int RDEPTH  = 4,
   parameter int TS_W    = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             attempt,
   input  logic             match,
   input  logic             fail,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [1:0]       res_code,
   output logic [TS_W-1:0]  res_lat,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] tmo_cnt,
   output logic             err_spurious,
   output logic             err_ovf,
   output logic             busy
`ifdef SEQ_MON_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]  res_ts
`endif
);

   localparam int AW  = $clog2(DEPTH);
   localparam int RW  = $clog2(RDEPTH);
   localparam int ACW = AW + 1;
   localparam int RCW = RW + 1;
   localparam logic [1:0] CODE_PASS = 2'b01;
   localparam logic [1:0] CODE_FAIL = 2'b10;
   localparam logic [1:0] CODE_TMO  = 2'b11;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   logic [TS_W-1:0]  r_now;
   logic [TS_W-1:0]  r_ats [DEPTH];
   logic [AW-1:0]    r_awp, r_arp;
   logic [ACW-1:0]   r_acnt;
   logic [1:0]       r_rcode [RDEPTH];
   logic [TS_W-1:0]  r_rlat  [RDEPTH];
`ifdef SEQ_MON_TIMESTAMP_EN
   logic [TS_W-1:0]  r_rts   [RDEPTH];
`endif
   logic [RW-1:0]    r_rwp, r_rrp;
   logic [RCW-1:0]   r_rcnt;
   logic [CNT_W-1:0] r_pass, r_fail, r_tmo;
   logic             r_spur, r_ovf, r_busy;

   logic             w_a_empty, w_pop, w_push, w_a_drop, w_spur;
   logic             w_res_valid, w_r_deq, w_r_enq, w_r_drop;
   logic [1:0]       w_code;
   logic [TS_W-1:0]  w_age;
   logic [ACW-1:0]   w_acnt_nxt;
   logic [RCW-1:0]   w_rcnt_nxt;

   // Verdict resolution against the oldest outstanding attempt; an explicit verdict beats the timeout.
   always_comb begin
      w_a_empty = (r_acnt == {ACW{1'b0}});
      w_age     = r_now - r_ats[r_arp];
      w_pop     = 1'b0;
      w_code    = CODE_TMO;
      if (w_a_empty) begin
         w_pop = 1'b0;
      end else if (match || fail) begin
         w_pop  = 1'b1;
         w_code = fail ? CODE_FAIL : CODE_PASS;
      end else if (w_age == TS_W'(TIMEOUT)) begin
         w_pop  = 1'b1;
         w_code = CODE_TMO;
      end else begin
         w_pop = 1'b0;
      end
      w_spur   = ((match || fail) && w_a_empty) || (match && fail);
      w_push   = attempt && ((r_acnt != ACW'(DEPTH)) || w_pop);
      w_a_drop = attempt && !w_push;
      if (w_push && !w_pop) begin
         w_acnt_nxt = r_acnt + ACW'(1);
      end else if (!w_push && w_pop) begin
         w_acnt_nxt = r_acnt - ACW'(1);
      end else begin
         w_acnt_nxt = r_acnt;
      end
   end

   // Result FIFO handshake; a consumer pop in the same cycle frees room for the new record.
   always_comb begin
      w_res_valid = (r_rcnt != {RCW{1'b0}});
      w_r_deq     = w_res_valid && res_ready;
      w_r_enq     = w_pop && ((r_rcnt != RCW'(RDEPTH)) || w_r_deq);
      w_r_drop    = w_pop && !w_r_enq;
      if (w_r_enq && !w_r_deq) begin
         w_rcnt_nxt = r_rcnt + RCW'(1);
      end else if (!w_r_enq && w_r_deq) begin
         w_rcnt_nxt = r_rcnt - RCW'(1);
      end else begin
         w_rcnt_nxt = r_rcnt;
      end
   end

   // FIFO payload storage; validity is tracked by the reset-controlled pointers and counts.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ats[r_awp] <= r_now;
      end
      if (w_r_enq) begin
         r_rcode[r_rwp] <= w_code;
         r_rlat[r_rwp]  <= w_age;
`ifdef SEQ_MON_TIMESTAMP_EN
         r_rts[r_rwp]   <= r_now;
`endif
      end
   end

   // Pointers, cycle counter, statistics and sticky error flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_now  <= {TS_W{1'b0}};
         r_awp  <= {AW{1'b0}};
         r_arp  <= {AW{1'b0}};
         r_acnt <= {ACW{1'b0}};
         r_rwp  <= {RW{1'b0}};
         r_rrp  <= {RW{1'b0}};
         r_rcnt <= {RCW{1'b0}};
         r_busy <= 1'b0;
         r_pass <= {CNT_W{1'b0}};
         r_fail <= {CNT_W{1'b0}};
         r_tmo  <= {CNT_W{1'b0}};
         r_spur <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_now  <= r_now + TS_W'(1);
         r_acnt <= w_acnt_nxt;
         r_busy <= (w_acnt_nxt != {ACW{1'b0}});
         r_rcnt <= w_rcnt_nxt;
         if (w_push)  r_awp <= r_awp + AW'(1);
         if (w_pop)   r_arp <= r_arp + AW'(1);
         if (w_r_enq) r_rwp <= r_rwp + RW'(1);
         if (w_r_deq) r_rrp <= r_rrp + RW'(1);
         if (clr) begin
            r_pass <= {CNT_W{1'b0}};
            r_fail <= {CNT_W{1'b0}};
            r_tmo  <= {CNT_W{1'b0}};
            r_spur <= 1'b0;
            r_ovf  <= 1'b0;
         end else begin
            if (w_pop && (w_code == CODE_PASS)) r_pass <= sat_inc(r_pass);
            if (w_pop && (w_code == CODE_FAIL)) r_fail <= sat_inc(r_fail);
            if (w_pop && (w_code == CODE_TMO))  r_tmo  <= sat_inc(r_tmo);
            if (w_spur) r_spur <= 1'b1;
            if (w_a_drop || w_r_drop) r_ovf <= 1'b1;
         end
      end
   end

   // Record fields read straight from the FIFO head, forced to zero when nothing is pending.
   always_comb begin
      res_valid = w_res_valid;
      if (w_res_valid) begin
         res_code = r_rcode[r_rrp];
         res_lat  = r_rlat[r_rrp];
      end else begin
         res_code = 2'b00;
         res_lat  = {TS_W{1'b0}};
      end
`ifdef SEQ_MON_TIMESTAMP_EN
      if (w_res_valid) begin
         res_ts = r_rts[r_rrp];
      end else begin
         res_ts = {TS_W{1'b0}};
      end
`endif
   end

   assign pass_cnt     = r_pass;
   assign fail_cnt     = r_fail;
   assign tmo_cnt      = r_tmo;
   assign err_spurious = r_spur;
   assign err_ovf      = r_ovf;
   assign busy         = r_busy;

endmodule
